// File: rtl/cmd_seq.sv
// rtl/cmd_seq.sv - scripted command sequencer driving a comm master
// Runs a stored table of {cmd, data, settle} entries, waiting for an ACK after each send.
module cmd_seq #(
  parameter int         DEPTH      = 8,
  parameter int         SET_W      = 25,
  parameter int         TMO_CYCLES = 150000,
  parameter logic [7:0] ACK        = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [7:0]                   wr_cmd,
  input  logic [15:0]                  wr_data,
  input  logic [SET_W-1:0]             wr_settle,
  input  logic [$clog2(DEPTH+1)-1:0]   len,
  input  logic                         start,
  input  logic                         abort,
  output logic [7:0]                   cmd,
  output logic [15:0]                  data,
  output logic                         send_cmd,
  input  logic                         frm_snt,
  input  logic                         resp_rdy,
  input  logic [7:0]                   resp,
  output logic                         clr_resp_rdy,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   err,
  output logic [$clog2(DEPTH)-1:0]     fail_idx
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int TMO_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [15:0]        data_q, data_d;
  logic               clr_q, clr_d;
  logic               busy_q, busy_d;
  logic               pass_q, pass_d;
  logic [1:0]         err_q, err_d;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
  logic               rdy_q, rdy_d;
  logic               rdy_prev_q, rdy_prev_d;

  // Script table is deliberately outside the reset domain so it survives rst_n.
  logic [7:0]         mem_cmd  [DEPTH];
  logic [15:0]        mem_data [DEPTH];
  logic [SET_W-1:0]   mem_set  [DEPTH];

  logic               rise;
  logic               is_last;
  logic [IDX_W-1:0]   nxt_idx;
  logic               unused_frm_snt;

  assign unused_frm_snt = frm_snt;
  // resp_rdy is registered twice so only a fresh low-to-high transition counts
  assign rise    = rdy_q & ~rdy_prev_q;
  assign is_last = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;
  assign nxt_idx = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      mem_cmd[wr_addr]  <= wr_cmd;
      mem_data[wr_addr] <= wr_data;
      mem_set[wr_addr]  <= wr_settle;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    set_d      = set_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    clr_d      = 1'b0;
    busy_d     = busy_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_idx_d = fail_idx_q;
    rdy_d      = resp_rdy;
    rdy_prev_d = rdy_q;

    if (abort && (state_q == ST_SEND || state_q == ST_WAIT_RESP || state_q == ST_SETTLE)) begin
      err_d      = 2'b11;
      fail_idx_d = idx_q;
      state_d    = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pass_d     = 1'b0;
            err_d      = 2'b00;
            fail_idx_d = '0;
            if (len != '0) begin
              len_d   = len;
              idx_d   = '0;
              busy_d  = 1'b1;
              cmd_d   = mem_cmd[0];
              data_d  = mem_data[0];
              state_d = ST_SEND;
            end else begin
              pass_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_SEND: begin
          tmo_d   = '0;
          state_d = ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          if (rise) begin
            clr_d = 1'b1;
            if (resp == ACK) begin
              set_d   = mem_set[idx_q];
              state_d = ST_SETTLE;
            end else begin
              err_d      = 2'b10;
              fail_idx_d = idx_q;
              state_d    = ST_DONE;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_d      = 2'b01;
            fail_idx_d = idx_q;
            state_d    = ST_DONE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (set_q == '0) begin
            if (is_last) begin
              pass_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              idx_d   = nxt_idx;
              cmd_d   = mem_cmd[nxt_idx];
              data_d  = mem_data[nxt_idx];
              state_d = ST_SEND;
            end
          end else begin
            set_d = set_q - 1'b1;
          end
        end
        ST_DONE: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
      set_q      <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 2'b00;
      fail_idx_q <= '0;
      rdy_q      <= 1'b0;
      rdy_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
      set_q      <= set_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_idx_q <= fail_idx_d;
      rdy_q      <= rdy_d;
      rdy_prev_q <= rdy_prev_d;
    end
  end

  assign cmd          = cmd_q;
  assign data         = data_q;
  assign send_cmd     = (state_q == ST_SEND);
  assign done         = (state_q == ST_DONE);
  assign clr_resp_rdy = clr_q;
  assign busy         = busy_q;
  assign pass         = pass_q;
  assign err          = err_q;
  assign fail_idx     = fail_idx_q;

endmodule

// File: doc/cmd_seq.md
CMD_SEQ -- requirements
Module: cmd_seq

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 8: script entries.
- SET_W, default 25: settle-counter width.
- TMO_CYCLES, default 150000: response timeout in clk cycles.
- ACK, default 8'hA5: positive-acknowledge byte.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the one clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- wr_en, in, 1: script write strobe.
- wr_addr, in, clog2(DEPTH): entry index.
- wr_cmd, in, 8: entry command byte.
- wr_data, in, 16: entry data word.
- wr_settle, in, SET_W: post-ack settle cycles.
- len, in, clog2(DEPTH+1): entries to run, sampled at start.
- start, in, 1: run request pulse.
- abort, in, 1: stop the run.
- cmd, out, 8: command to the comm master.
- data, out, 16: data to the comm master.
- send_cmd, out, 1: one-cycle send pulse.
- frm_snt, in, 1: frame-sent from the comm master (status only).
- resp_rdy, in, 1: response-valid level from the comm master.
- resp, in, 8: response byte.
- clr_resp_rdy, out, 1: one-cycle clear pulse.
- busy, out, 1: run in progress.
- done, out, 1: one-cycle end-of-run pulse.
- pass, out, 1: last run result.
- err, out, 2: 00 none, 01 timeout, 10 nak, 11 abort.
- fail_idx, out, clog2(DEPTH): entry index at failure.

Function
REQ-003 Script storage SHALL be DEPTH entries of {cmd 8, data 16, settle SET_W}, written on the clk edge when wr_en=1; writes SHALL be ignored while busy=1.
REQ-004 FSM states SHALL be IDLE, SEND, WAIT_RESP, SETTLE, DONE.
REQ-005 IDLE with start=1 and len>0 SHALL latch len, clear idx to 0, clear pass, err and fail_idx, set busy, and go to SEND.
REQ-006 IDLE with start=1 and len=0 SHALL go directly to DONE with pass=1 and err=00.
REQ-007 start SHALL be ignored in every state except IDLE.
REQ-008 SEND SHALL drive cmd and data from entry[idx], assert send_cmd for exactly 1 cycle, clear the timeout counter, and go to WAIT_RESP on the next edge.
REQ-009 cmd and data SHALL hold their values until the next SEND.
REQ-010 WAIT_RESP SHALL act only on a resp_rdy rising edge, from a registered previous value, never on a stale high level.
REQ-011 In WAIT_RESP, a rising edge with resp==ACK SHALL pulse clr_resp_rdy for 1 cycle, load the settle counter with entry[idx].settle, and go to SETTLE.
REQ-012 In WAIT_RESP, a rising edge with resp!=ACK SHALL pulse clr_resp_rdy, set err=10 and fail_idx=idx, and go to DONE.
REQ-013 The timeout counter SHALL increment each cycle in WAIT_RESP; on reaching TMO_CYCLES-1 without a rising edge, err=01, fail_idx=idx, and the FSM SHALL go to DONE.
REQ-014 When a response edge and the timeout occur in the same cycle, the response SHALL win.
REQ-015 SETTLE SHALL decrement each cycle and exit when the count is 0, so settle=0 costs 1 cycle and settle=N costs N+1 cycles.
REQ-016 On SETTLE exit, if idx==len-1 then pass=1 and the FSM SHALL go to DONE; otherwise idx SHALL increment and the FSM SHALL go to SEND.
REQ-017 DONE SHALL pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-018 pass, err and fail_idx SHALL hold after DONE until the next accepted start.
REQ-019 abort=1 in any non-IDLE state SHALL take priority over all other events, set err=11 and fail_idx=idx, and go to DONE.
REQ-020 abort=1 in IDLE SHALL be ignored.
REQ-021 Counters SHALL saturate and never wrap: the timeout counter is sized clog2(TMO_CYCLES); idx never exceeds len-1.
REQ-022 frm_snt SHALL NOT affect control flow.

Reset
REQ-023 On rst_n low, asynchronously:
- state SHALL be IDLE.
- cmd, data, send_cmd, clr_resp_rdy, busy, done, pass, err, fail_idx and all counters SHALL be 0.
- Script storage SHALL NOT be cleared.
REQ-024 Reset asserted mid-run SHALL abandon the run without producing a done pulse.
REQ-025 After reset deassertion, the first start SHALL run the script written before reset.

Verification
REQ-026 Bench SHALL cover these directed scenarios:
- Nominal: 3 entries {06,0000,0}, {05,01FF,10}, {04,00FF,0}, ACK returned 5 cycles after each send_cmd -> exactly 3 send_cmd pulses, cmd sequence 06, 05, 04, done with pass=1, err=00.
- NAK: entry1 response 8'hEE -> done, pass=0, err=10, fail_idx=1, no third send_cmd.
- Timeout: TMO_CYCLES=100, no response -> done exactly 100 cycles after WAIT_RESP entry, err=01, fail_idx=0.
- Settle: settle=10 -> next send_cmd exactly 13 cycles after the ack edge (1 WAIT_RESP exit + 11 SETTLE + 1 SEND).
- Abort/edges: abort during SETTLE -> err=11; resp_rdy held high from the prior entry -> no false acceptance; len=0 -> immediate done with pass=1; wr_en while busy -> table unchanged.
- Reset: rst_n low during WAIT_RESP -> all outputs 0 with no done pulse; a following start replays the stored script successfully.
